// File: rtl/alu_cc_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_cc_stage_if
// Description : Bundles the signals between the ALU, the execute back end
//               (alu_cc_stage) and the memory stage.
//                 upstream   : in_valid/in_ready, in_icode, in_ifun,
//                              alu_result, alu_overflow, flush
//                 downstream : out_valid/out_ready, out_icode, out_valE,
//                              out_cnd
//               slave  = stage view (consumes ALU side, produces E->M side)
//               master = environment view (ALU + memory stage)
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_cc_stage_if #(
    parameter int W = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_icode;
    logic [3:0]   in_ifun;
    logic [W-1:0] alu_result;
    logic         alu_overflow;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_icode;
    logic [W-1:0] out_valE;
    logic         out_cnd;

    modport slave (
        input  in_valid, in_icode, in_ifun, alu_result, alu_overflow, flush,
        input  out_ready,
        output in_ready, out_valid, out_icode, out_valE, out_cnd
    );

    modport master (
        output in_valid, in_icode, in_ifun, alu_result, alu_overflow, flush,
        output out_ready,
        input  in_ready, out_valid, out_icode, out_valE, out_cnd
    );
endinterface
`default_nettype wire

// File: rtl/alu_cc_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_cc_stage
// Description : Y86-64 execute-stage back end. Registers valE/icode/Cnd into
//               the E->M pipeline register behind a valid/ready handshake,
//               maintains the ZF/SF/OF condition codes (updated by OPq only)
//               and evaluates the jXX/cmovXX condition from the codes as
//               they stood before this cycle's update.
// Ports       : clk, rst (async, active high)
//               bus       - alu_cc_stage_if.slave (handshakes + data)
//               cc_zf/sf/of - current condition codes
//               cnt_ccupd, cnt_taken - event counters (ALU_CC_COUNT_EN only)
// Options     : `define ALU_CC_COUNT_EN adds the CNT_W-wide counters.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cc_stage #(
    parameter int W = 64
`ifdef ALU_CC_COUNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    alu_cc_stage_if.slave    bus,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
`ifdef ALU_CC_COUNT_EN
    ,
    output logic [CNT_W-1:0] cnt_ccupd,
    output logic [CNT_W-1:0] cnt_taken
`endif
);

    localparam logic [3:0] c_icode_cmov = 4'h2;
    localparam logic [3:0] c_icode_opq  = 4'h6;
    localparam logic [3:0] c_icode_jxx  = 4'h7;

    logic         r_valid;
    logic [3:0]   r_icode;
    logic [W-1:0] r_valE;
    logic         r_cnd;
    logic         r_zf;
    logic         r_sf;
    logic         r_of;

    logic         w_in_ready;
    logic         w_accept;
    logic         w_cc_upd;
    logic         w_is_branch;
    logic         w_cond;
    logic         w_cnd;

    assign w_in_ready  = !r_valid || bus.out_ready;
    assign w_accept    = bus.in_valid && w_in_ready && !bus.flush;
    assign w_cc_upd    = w_accept && (bus.in_icode == c_icode_opq);
    assign w_is_branch = (bus.in_icode == c_icode_cmov) || (bus.in_icode == c_icode_jxx);

    // Condition evaluated on the registered codes, so an OPq accepted on
    // the same edge does not affect this instruction's Cnd.
    always_comb begin
        w_cond = 1'b0;
        case (bus.in_ifun)
            4'h0:    w_cond = 1'b1;
            4'h1:    w_cond = (r_sf ^ r_of) | r_zf;
            4'h2:    w_cond = r_sf ^ r_of;
            4'h3:    w_cond = r_zf;
            4'h4:    w_cond = !r_zf;
            4'h5:    w_cond = !(r_sf ^ r_of);
            4'h6:    w_cond = !(r_sf ^ r_of) && !r_zf;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_cnd = w_is_branch && w_cond;

    // E->M pipeline register; flush wins over both stall and accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_icode <= 4'h0;
            r_valE  <= '0;
            r_cnd   <= 1'b0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_icode <= bus.in_icode;
            r_valE  <= bus.alu_result;
            r_cnd   <= w_cnd;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Condition-code register; ZF resets to 1 as for a zero result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zf <= 1'b1;
            r_sf <= 1'b0;
            r_of <= 1'b0;
        end else if (w_cc_upd) begin
            r_zf <= (bus.alu_result == '0);
            r_sf <= bus.alu_result[W-1];
            r_of <= bus.alu_overflow;
        end
    end

`ifdef ALU_CC_COUNT_EN
    logic [CNT_W-1:0] r_cnt_ccupd;
    logic [CNT_W-1:0] r_cnt_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_ccupd <= '0;
            r_cnt_taken <= '0;
        end else begin
            if (w_cc_upd) begin
                r_cnt_ccupd <= r_cnt_ccupd + 1'b1;
            end
            if (w_accept && w_cnd) begin
                r_cnt_taken <= r_cnt_taken + 1'b1;
            end
        end
    end

    assign cnt_ccupd = r_cnt_ccupd;
    assign cnt_taken = r_cnt_taken;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_valid;
    assign bus.out_icode = r_icode;
    assign bus.out_valE  = r_valE;
    assign bus.out_cnd   = r_cnd;
    assign cc_zf         = r_zf;
    assign cc_sf         = r_sf;
    assign cc_of         = r_of;

endmodule
`default_nettype wire
